// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_t;

  localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: tick while the count is zero, then reload a full period.
module uart_bit_timer #(
  parameter int MAX = 434,
  parameter int W   = $clog2(MAX)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tick
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             r_cnt <= '0;
    else if (load)          r_cnt <= load_val;
    else if (r_cnt == '0)   r_cnt <= W'(MAX - 1);
    else                    r_cnt <= r_cnt - 1'b1;
  end

  assign tick = (r_cnt == '0);

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// 8N1 receive sequencer: line sync, start/data/stop sampling, one-entry holding
// register towards the consumer, framing and overrun pulses.
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int BAUD_DIV  = 434,
  parameter int DATA_BITS = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int TW = $clog2(BAUD_DIV);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] HALF_LOAD = TW'(BAUD_DIV / 2 - 1);
  localparam logic [TW-1:0] FULL_LOAD = TW'(BAUD_DIV - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);

  logic                 r_sync1, r_sync2, r_rx_prev;
  logic                 w_rx_s, w_fall, w_tick;
  rx_state_t            r_state, w_next;
  logic                 w_load, w_idx_clr, w_shift_en, w_deliver, w_ferr;
  logic [TW-1:0]        w_load_val;
  logic [IW-1:0]        r_idx;
  logic [DATA_BITS-1:0] r_shift, r_rx_data;
  logic                 r_rx_valid, r_frame_err, r_overrun_err;

  // Sync flops idle high so reset never looks like a start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= rx;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

  assign w_rx_s = r_sync2;
  assign w_fall = r_rx_prev & ~w_rx_s;

  uart_bit_timer #(.MAX(BAUD_DIV), .W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (w_load),
    .load_val (w_load_val),
    .tick     (w_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = FULL_LOAD;
    w_idx_clr  = 1'b0;
    w_shift_en = 1'b0;
    w_deliver  = 1'b0;
    w_ferr     = 1'b0;
    case (r_state)
      IDLE: if (w_fall) begin
        w_next     = START;
        w_load     = 1'b1;
        w_load_val = HALF_LOAD;
      end
      START: if (w_tick) begin
        if (!w_rx_s) begin
          w_next    = DATA;
          w_load    = 1'b1;
          w_idx_clr = 1'b1;
        end else begin
          w_next = IDLE;
        end
      end
      DATA: if (w_tick) begin
        w_shift_en = 1'b1;
        if (r_idx == LAST_BIT) w_next = STOP;
      end
      STOP: if (w_tick) begin
        if (w_rx_s) begin
          w_deliver = 1'b1;
          w_next    = IDLE;
        end else begin
          w_ferr = 1'b1;
          w_next = WAIT_IDLE;
        end
      end
      // A held-low line (break) must go high before a new start is accepted.
      WAIT_IDLE: if (w_rx_s) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx   <= '0;
      r_shift <= '0;
    end else if (w_idx_clr) begin
      r_idx <= '0;
    end else if (w_shift_en) begin
      r_idx   <= r_idx + 1'b1;
      r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
    end
  end

  // Consumer handshake and delivery in the same cycle counts as a free slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      r_frame_err   <= w_ferr;
      r_overrun_err <= w_deliver & r_rx_valid & ~rx_ready;
      if (w_deliver && (!r_rx_valid || rx_ready)) begin
        r_rx_data  <= r_shift;
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign frame_err   = r_frame_err;
  assign overrun_err = r_overrun_err;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl: frame-level reference model feeds expected
// bytes and error events; a negedge monitor compares whatever the DUT presents.
module tb_uart_rx_frame_ctrl;

  localparam int BAUD   = 8;
  // Cycle offset (from the start-bit drive edge) of the stop-bit delivery cycle.
  localparam int DELIV  = 2 + BAUD / 2 + 9 * BAUD;
  localparam int E_FRAME = 1;
  localparam int E_OVR   = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun_err, busy;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_bytes[$];
  int         exp_errs[$];
  bit         model_full = 1'b0;

  uart_rx_frame_ctrl #(.BAUD_DIV(BAUD), .DATA_BITS(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .busy        (busy)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Ready is held at rdy for the whole frame; pulse=1 raises it only in the delivery cycle.
  task automatic send_frame(logic [7:0] d, bit stop_ok, bit rdy, bit pulse);
    logic [9:0] fr;
    fr = {stop_ok, d, 1'b0};
    if (pulse) begin
      exp_bytes.push_back(d);
      model_full = 1'b1;
    end else begin
      if (rdy) model_full = 1'b0;
      if (!stop_ok)                 exp_errs.push_back(E_FRAME);
      else if (model_full && !rdy)  exp_errs.push_back(E_OVR);
      else begin
        exp_bytes.push_back(d);
        model_full = !rdy;
      end
    end
    rx_ready = rdy;
    for (int c = 0; c < 10 * BAUD; c++) begin
      rx = fr[c / BAUD];
      if (pulse) rx_ready = (c == DELIV);
      @(posedge clk);
      #1;
    end
    if (pulse) rx_ready = rdy;
  endtask

  task automatic good_frame(logic [7:0] d, bit rdy);
    send_frame(d, 1'b1, rdy, 1'b0);
    rx = 1'b1;
    cyc(4 + $urandom_range(0, 5));
    check("busy_after_frame", 32'(busy), 0);
  endtask

  task automatic bad_frame(logic [7:0] d, bit rdy, int hold_bits);
    send_frame(d, 1'b0, rdy, 1'b0);
    cyc(hold_bits * BAUD);
    check("busy_in_break", 32'(busy), 1);
    rx = 1'b1;
    cyc(6);
    check("busy_after_break", 32'(busy), 0);
  endtask

  task automatic glitch(int n);
    rx = 1'b0;
    cyc(n);
    rx = 1'b1;
    cyc(4 - n);
    check("busy_in_glitch", 32'(busy), 1);
    cyc(10);
    check("busy_after_glitch", 32'(busy), 0);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_rx_data"}, 32'(rx_data), 0);
    check({tag, "_rx_valid"}, 32'(rx_valid), 0);
    check({tag, "_frame_err"}, 32'(frame_err), 0);
    check({tag, "_overrun_err"}, 32'(overrun_err), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  // Monitor: byte transfers, error pulses and holding-register stability.
  initial begin
    logic [7:0] prev_data;
    bit         prev_hold;
    logic [7:0] e;
    int         code, ecode;
    prev_hold = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (prev_hold && rx_valid) begin
          tests++;
          if (rx_data !== prev_data) begin
            fails++;
            $display("FAIL hold_stable: got 0x%0h required 0x%0h", rx_data, prev_data);
          end
        end
        if (rx_valid && rx_ready) begin
          tests++;
          if (exp_bytes.size() == 0) begin
            fails++;
            $display("FAIL byte_unexpected: got 0x%0h required no transfer", rx_data);
          end else begin
            e = exp_bytes.pop_front();
            if (rx_data !== e) begin
              fails++;
              $display("FAIL byte_data: got 0x%0h required 0x%0h", rx_data, e);
            end
          end
        end
        if (frame_err || overrun_err) begin
          tests++;
          code = frame_err ? (overrun_err ? 3 : E_FRAME) : E_OVR;
          if (exp_errs.size() == 0) begin
            fails++;
            $display("FAIL err_unexpected: got code %0d required none", code);
          end else begin
            ecode = exp_errs.pop_front();
            if (code != ecode) begin
              fails++;
              $display("FAIL err_kind: got code %0d required %0d", code, ecode);
            end
          end
        end
        prev_hold = rx_valid && !rx_ready;
        prev_data = rx_data;
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  initial begin
    logic [9:0] fr;
    reset = 1'b0;
    rx = 1'b1;
    rx_ready = 1'b0;
    cyc(3);
    check_all_zero("reset");
    reset = 1'b1;
    cyc(5);

    // Clean frame straight through
    good_frame(8'hA5, 1'b1);
    check("a5_consumed", 32'(rx_valid), 0);

    // Short low pulse rejected at the start-bit sample
    glitch(3);

    // Break: framing error, parked until line returns high, then normal reception
    bad_frame(8'h3C, 1'b1, 20);
    check("after_break_valid", 32'(rx_valid), 0);
    good_frame(8'h3C, 1'b1);

    // Overrun while holding 0x11, then single-cycle drain
    good_frame(8'h11, 1'b0);
    good_frame(8'h22, 1'b0);
    check("ovr_hold_valid", 32'(rx_valid), 1);
    check("ovr_hold_data", 32'(rx_data), 32'h11);
    rx_ready = 1'b1;
    cyc(1);
    rx_ready = 1'b0;
    model_full = 1'b0;
    check("ovr_drained", 32'(rx_valid), 0);

    // Consumer accepts exactly in the delivery cycle: swap without overrun
    good_frame(8'h11, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b1);
    rx = 1'b1;
    cyc(4);
    check("swap_valid", 32'(rx_valid), 1);
    check("swap_data", 32'(rx_data), 32'h22);
    rx_ready = 1'b1;
    cyc(2);
    model_full = 1'b0;

    // Reset mid-frame with a byte held
    good_frame(8'h77, 1'b0);
    fr = {1'b1, 8'hFF, 1'b0};
    for (int c = 0; c < 5 * BAUD + 4; c++) begin
      rx = fr[c / BAUD];
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_bytes.delete();
    model_full = 1'b0;
    rx = 1'b1;
    cyc(3);
    reset = 1'b1;
    cyc(5);
    good_frame(8'h5A, 1'b0);
    check("post_reset_valid", 32'(rx_valid), 1);
    check("post_reset_data", 32'(rx_data), 32'h5A);

    // Randomized mix of frames, breaks, glitches and consumer stalls
    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0)      glitch($urandom_range(1, 3));
      else if (r == 1) bad_frame(8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(1, 3));
      else             good_frame(8'($urandom), 1'($urandom_range(0, 1)));
    end

    rx_ready = 1'b1;
    cyc(5);
    check("bytes_outstanding", exp_bytes.size(), 0);
    check("errs_outstanding", exp_errs.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
